core_ctrl_fsm: RTL

// Multi-cycle sequencer for the RV32I core. It owns the fetch/decode/execute/memory/writeback order.
// It drives the IR, PC and register-file write enables, the PC and writeback muxes, and the imem/dmem request handshakes.
// It consumes the opcode_map one-hot from the decoder (combinational from the IR) and the branch-compare result.
// One instruction is in flight at a time; each instruction retires exactly once, or traps.

---
 rtl/core_ctrl_fsm_pkg.sv | 68 ++++++
 rtl/ctrl_mem_timer.sv | 40 ++++
 rtl/core_ctrl_fsm.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/core_ctrl_fsm_pkg.sv
// -----------------------------------------------------------------------------
// core_ctrl_fsm_pkg
// Shared types for the RV32I multi-cycle control sequencer:
//   opcode_map   - one-hot major-opcode class produced by the decoder from the IR
//   ctrl_state_e - sequencer states
//   pc_sel_e     - PC source mux select
//   wb_sel_e     - register-file writeback mux select
//   trap_cause_e - cause reported alongside the trap pulse
// -----------------------------------------------------------------------------
package core_ctrl_fsm_pkg;

    localparam int MEM_TIMEOUT_DEFAULT = 16;

    // 'other' is raised by the decoder for any major opcode outside RV32I.
    typedef struct packed {
        logic other;
        logic system;
        logic misc_mem;
        logic auipc;
        logic lui;
        logic op;
        logic op_imm;
        logic jalr;
        logic jal;
        logic branch;
        logic store;
        logic load;
    } opcode_map;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_FWAIT  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_MWAIT  = 3'd5,
        ST_WB     = 3'd6,
        ST_TRAP   = 3'd7
    } ctrl_state_e;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'd0,
        PC_BRJAL = 2'd1,
        PC_JALR  = 2'd2,
        PC_TRAP  = 2'd3
    } pc_sel_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wb_sel_e;

    typedef enum logic [1:0] {
        CAUSE_ILLEGAL = 2'd0,
        CAUSE_ECALL   = 2'd1,
        CAUSE_BUS     = 2'd2
    } trap_cause_e;

    // True for the opcode classes that execute normally (SYSTEM is handled
    // separately because it traps with its own cause).
    function automatic logic is_executable(input opcode_map op);
        return !op.other && (op.load | op.store | op.branch | op.jal | op.jalr |
                             op.op_imm | op.op | op.lui | op.auipc | op.misc_mem);
    endfunction

endpackage

// File: rtl/ctrl_mem_timer.sv
// -----------------------------------------------------------------------------
// ctrl_mem_timer
// Counts cycles spent waiting for a memory response and flags the last
// allowed cycle so the sequencer can raise a bus trap.
//   clk        in   core clock
//   rst_n      in   synchronous, active-low reset
//   i_clear    in   restart the count (asserted on the cycle entering a wait)
//   i_enable   in   one waiting cycle elapsed
//   o_expired  out  count has reached MEM_TIMEOUT-1; never set when MEM_TIMEOUT=0
// -----------------------------------------------------------------------------
module ctrl_mem_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    logic [CNT_W-1:0] r_count;

    assign o_expired = (MEM_TIMEOUT != 0) && (r_count == CNT_W'(MEM_TIMEOUT - 1));

    // NOTE: registers are written with <= so every flop samples the pre-edge
    // values regardless of statement order inside the block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            // Saturates at the expiry value; the sequencer leaves the wait then.
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/core_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// core_ctrl_fsm
// Multi-cycle sequencer for the RV32I core: FETCH -> FWAIT -> DECODE -> EXEC
// -> (MEM -> MWAIT) -> WB, with a TRAP state for ECALL, illegal opcodes and
// memory response timeouts. One instruction is in flight at a time.
//   clk, rst_n                  clock, synchronous active-low reset
//   op_decode_pkt               one-hot opcode class, valid from DECODE onward
//   br_taken                    branch compare result, sampled in EXEC
//   imem_req/gnt/rvalid         instruction fetch handshake
//   dmem_req/we/gnt/rvalid      data access handshake
//   ir_we, pc_we, pc_sel        IR capture, PC update and PC source
//   rf_we, wb_sel               register write enable and writeback source
//   trap, trap_cause            trap pulse and its cause (cause held)
//   instret                     retire pulse
// -----------------------------------------------------------------------------
module core_ctrl_fsm
    import core_ctrl_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  opcode_map   op_decode_pkt,
    input  logic        br_taken,
    output logic        imem_req,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    output logic        ir_we,
    output logic        pc_we,
    output pc_sel_e     pc_sel,
    output logic        rf_we,
    output wb_sel_e     wb_sel,
    output logic        trap,
    output trap_cause_e trap_cause,
    output logic        instret
);

    ctrl_state_e r_state;
    ctrl_state_e w_next_state;
    logic        r_br_taken;
    trap_cause_e r_trap_cause;
    trap_cause_e w_trap_cause_nxt;
    logic        r_run;
    logic        w_tmr_clear;
    logic        w_tmr_en;
    logic        w_tmr_expired;

    ctrl_mem_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_tmr_clear),
        .i_enable  (w_tmr_en),
        .o_expired (w_tmr_expired)
    );

    // r_run keeps the first cycle after reset silent: every output is 0 while
    // the memories, reset by the same rst_n, come out of reset alongside us.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_FETCH;
            r_br_taken   <= 1'b0;
            r_trap_cause <= CAUSE_ILLEGAL;
            r_run        <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_run   <= 1'b1;
            if (r_state == ST_EXEC) begin
                r_br_taken <= br_taken;
            end
            // Cause is captured on entry to TRAP so it is visible with the pulse.
            if (w_next_state == ST_TRAP) begin
                r_trap_cause <= w_trap_cause_nxt;
            end
        end
    end

    assign trap_cause = r_trap_cause;

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_next_state     = r_state;
        w_trap_cause_nxt = r_trap_cause;
        w_tmr_clear      = 1'b0;
        w_tmr_en         = 1'b0;
        imem_req         = 1'b0;
        dmem_req         = 1'b0;
        dmem_we          = 1'b0;
        ir_we            = 1'b0;
        pc_we            = 1'b0;
        pc_sel           = PC_PLUS4;
        rf_we            = 1'b0;
        wb_sel           = WB_ALU;
        trap             = 1'b0;
        instret          = 1'b0;

        case (r_state)
            ST_FETCH: begin
                if (r_run) begin
                    imem_req = 1'b1;
                    if (imem_gnt) begin
                        w_next_state = ST_FWAIT;
                        w_tmr_clear  = 1'b1;
                    end
                end
            end
            ST_FWAIT: begin
                w_tmr_en = 1'b1;
                // A response on the last allowed cycle beats the timeout.
                if (imem_rvalid) begin
                    ir_we        = 1'b1;
                    w_next_state = ST_DECODE;
                end else if (w_tmr_expired) begin
                    w_next_state     = ST_TRAP;
                    w_trap_cause_nxt = CAUSE_BUS;
                end
            end
            ST_DECODE: begin
                if (op_decode_pkt.system) begin
                    w_next_state     = ST_TRAP;
                    w_trap_cause_nxt = CAUSE_ECALL;
                end else if (is_executable(op_decode_pkt)) begin
                    w_next_state = ST_EXEC;
                end else begin
                    w_next_state     = ST_TRAP;
                    w_trap_cause_nxt = CAUSE_ILLEGAL;
                end
            end
            ST_EXEC: begin
                w_next_state = (op_decode_pkt.load || op_decode_pkt.store) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = op_decode_pkt.store;
                if (dmem_gnt) begin
                    w_next_state = ST_MWAIT;
                    w_tmr_clear  = 1'b1;
                end
            end
            ST_MWAIT: begin
                w_tmr_en = 1'b1;
                if (dmem_rvalid) begin
                    w_next_state = ST_WB;
                end else if (w_tmr_expired) begin
                    w_next_state     = ST_TRAP;
                    w_trap_cause_nxt = CAUSE_BUS;
                end
            end
            ST_WB: begin
                pc_we   = 1'b1;
                instret = 1'b1;
                if (op_decode_pkt.jal || (op_decode_pkt.branch && r_br_taken)) begin
                    pc_sel = PC_BRJAL;
                end else if (op_decode_pkt.jalr) begin
                    pc_sel = PC_JALR;
                end
                rf_we = op_decode_pkt.op  | op_decode_pkt.op_imm | op_decode_pkt.lui   |
                        op_decode_pkt.auipc | op_decode_pkt.load | op_decode_pkt.jal   |
                        op_decode_pkt.jalr;
                if (op_decode_pkt.load) begin
                    wb_sel = WB_MEM;
                end else if (op_decode_pkt.jal || op_decode_pkt.jalr) begin
                    wb_sel = WB_PC4;
                end else if (op_decode_pkt.lui) begin
                    wb_sel = WB_IMM;
                end
                w_next_state = ST_FETCH;
            end
            ST_TRAP: begin
                trap         = 1'b1;
                pc_we        = 1'b1;
                pc_sel       = PC_TRAP;
                w_next_state = ST_FETCH;
            end
            default: begin
                w_next_state = ST_FETCH;
            end
        endcase
    end

    a_pc_we_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
        pc_we |-> (instret ^ trap));

    a_single_bus_req : assert property (@(posedge clk)
        !(imem_req && dmem_req));

endmodule
